filter_frame_sequencer: RTL and testbench
=========================================

// Module: filter_frame_sequencer
// PURPOSE
//  Frame-level controller for the edge-detect/binarisation filter. It owns the single-port 320x240x12 frame buffer.
//  The buffer is granted to the camera writer during capture and to the filter during processing.
//  The block sequences the filter's waiting_for_new_frame/enable handshake and latches per-frame results (centroid, stop).
//  It also polices runaway frames with a watchdog.
// PARAMETERS
//  WIDTH          320     frame width, pixels
//  HEIGHT         240     frame height, pixels
//  ADDR_W         17      frame-buffer address width
//  PIX_W          12      pixel width (4:4:4 RGB)
//  TIMEOUT_CYCLES 200000  max cycles in FILTER before abort; legal range >=2
// PORTS
//  clk                    in   1       system clock
//  reset                  in   1       synchronous, active-low reset
//  run_en                 in   1       allow new frames to start
//  cam_frame_start        in   1       1-cycle pulse, camera frame begins
//  cam_frame_end          in   1       1-cycle pulse, last camera pixel written
//  cam_wr_en              in   1       camera pixel write strobe
//  cam_addr               in   ADDR_W  camera pixel address
//  cam_data               in   PIX_W   camera pixel
//  flt_waiting_for_new_frame out 1     to filter: hold/idle
//  flt_enable             out  1       to filter: run
//  flt_frame_done         in   1       filter finished frame (pulse)
//  flt_wr_enable          in   1       filter write strobe
//  flt_read_addr          in   ADDR_W  filter read address
//  flt_write_addr         in   ADDR_W  filter write address
//  flt_data_out           in   PIX_W   filter write data
//  flt_h_centroid         in   10      filter centroid, valid with frame_done
//  flt_stop_detect        in   1       filter stop flag, valid with frame_done
//  mem_addr               out  ADDR_W  frame-buffer address
//  mem_wr_en              out  1       frame-buffer write enable
//  mem_wdata              out  PIX_W   frame-buffer write data
//  centroid               out  10      last latched centroid
//  stop                   out  1       last latched stop flag
//  result_valid           out  1       1-cycle pulse, new result latched
//  busy                   out  1       high in any state except IDLE
//  timeout_err            out  1       sticky, set on watchdog abort
//  frame_count            out  16      completed frames, wraps at 2^16
//  dropped_count          out  8       camera frames ignored, saturates at 255
// BEHAVIOUR
//  - Reset (reset==0 at posedge clk):
//    - state=IDLE; flt_waiting_for_new_frame=1; flt_enable=0.
//    - centroid=0, stop=0, result_valid=0, busy=0, timeout_err=0, frame_count=0, dropped_count=0, watchdog=0.
//    - Reset mid-frame aborts immediately; no result is latched.
//  - FSM, state registered; the memory mux is combinational from state (0 latency).
//  - IDLE:
//    - mem_wr_en=0, mem_addr=0.
//    - cam_frame_start & run_en -> CAPTURE.
//    - cam_frame_start & !run_en is ignored; it is not counted as dropped.
//  - CAPTURE:
//    - mem_addr=cam_addr, mem_wdata=cam_data.
//    - mem_wr_en = cam_wr_en & (cam_addr < WIDTH*HEIGHT); out-of-range writes are suppressed.
//    - cam_frame_end -> ARM.
//    - run_en==0 -> IDLE (abort, no count).
//    - Simultaneous end and start: end wins; the start counts as dropped.
//  - ARM (1 cycle): flt_waiting_for_new_frame=0, flt_enable=1, filter owns memory, watchdog cleared; -> FILTER.
//  - FILTER:
//    - waiting=0, enable=1.
//    - mem_addr = flt_wr_enable ? flt_write_addr : flt_read_addr; mem_wr_en = flt_wr_enable; mem_wdata = flt_data_out.
//    - Camera writes are discarded; every cam_frame_start increments dropped_count (saturating).
//    - run_en deassert does not abort.
//    - flt_frame_done -> LATCH.
//    - Watchdog reaching TIMEOUT_CYCLES-1 without done -> IDLE with timeout_err=1.
//    - done and timeout in the same cycle: done wins.
//  - LATCH (1 cycle):
//    - centroid/stop are captured from the flt_* values registered on the done cycle.
//    - result_valid=1; frame_count+1; waiting=1, enable=0; -> IDLE.
//  - Throughput: one result at most per camera frame; frames arriving while busy outside IDLE are dropped, never queued.
// STRUCTURE
//  - frame_ctrl_defs.vh: state encodings (IDLE, CAPTURE, ARM, FILTER, LATCH) and localparam FRAME_PIXELS=WIDTH*HEIGHT.
//  - Sub-module frame_watchdog: clear/enable counter with terminal-count output, parameter TIMEOUT_CYCLES.
//  - Everything else lives in this module: FSM, mux, result registers, counters.
// TESTING
//  1. reset=0 for 5 cycles while pulsing cam_frame_start -> all outputs at reset values, busy=0, dropped_count=0.
//  2. run_en=1, start, writes to addr 0..76799, end -> mem_wr_en mirrors cam_wr_en; ARM next cycle with flt_enable=1, waiting=0.
//  3. FILTER with flt_read_addr=100 -> mem_addr=100, mem_wr_en=0; then flt_wr_enable=1, write_addr=200 -> mem_addr=200, mem_wr_en=1; cam_frame_start -> dropped_count=1.
//  4. flt_frame_done with centroid=160, stop=1 -> one-cycle result_valid, centroid=160, stop=1, frame_count=1, waiting=1.
//  5. TIMEOUT_CYCLES=1000, no done -> after 1000 FILTER cycles timeout_err=1, state IDLE, frame_count unchanged.
//  6. run_en=0 mid-CAPTURE -> IDLE next cycle, no ARM; a cam_addr=76800 write in CAPTURE -> mem_wr_en=0.

Source files
------------

// File: rtl/filter_frame_sequencer_pkg.sv
// filter_frame_sequencer_pkg: frame-controller state encoding and default frame geometry
package filter_frame_sequencer_pkg;
  localparam int WIDTH_DEF = 320;
  localparam int HEIGHT_DEF = 240;
  localparam int ADDR_W_DEF = 17;
  localparam int PIX_W_DEF = 12;
  localparam int TIMEOUT_DEF = 200000;
  typedef enum logic [2:0] {IDLE, CAPTURE, ARM, FILTER, LATCH} state_t;
endpackage

// File: rtl/filter_frame_sequencer_watchdog.sv
// filter_frame_sequencer_watchdog: clear/enable cycle counter that holds at its terminal count
module filter_frame_sequencer_watchdog #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] count;
  always_ff @(posedge clk)
    if (!reset || clear) count <= '0;
    else if (en && !tc) count <= count + 1'b1;
  assign tc = count == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/filter_frame_sequencer.sv
// filter_frame_sequencer: owns the frame buffer, sequences capture/filter and latches per-frame results
module filter_frame_sequencer
  import filter_frame_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  input  logic              cam_frame_start,
  input  logic              cam_frame_end,
  input  logic              cam_wr_en,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [PIX_W-1:0]  cam_data,
  output logic              flt_waiting_for_new_frame,
  output logic              flt_enable,
  input  logic              flt_frame_done,
  input  logic              flt_wr_enable,
  input  logic [ADDR_W-1:0] flt_read_addr,
  input  logic [ADDR_W-1:0] flt_write_addr,
  input  logic [PIX_W-1:0]  flt_data_out,
  input  logic [9:0]        flt_h_centroid,
  input  logic              flt_stop_detect,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic [9:0]        centroid,
  output logic              stop,
  output logic              result_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       frame_count,
  output logic [7:0]        dropped_count
);
  localparam int FRAME_PIXELS = WIDTH * HEIGHT;
  state_t state, next;
  logic tc, flt_owns, done_stop;
  logic [9:0] done_cent;

  filter_frame_sequencer_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .reset(reset),
    .clear(state == ARM),
    .en(state == FILTER),
    .tc(tc)
  );

  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (cam_frame_start && run_en) next = CAPTURE;
      CAPTURE: if (cam_frame_end) next = ARM; else if (!run_en) next = IDLE;
      ARM:     next = FILTER;
      FILTER:  if (flt_frame_done) next = LATCH; else if (tc) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Buffer ownership is a pure function of state so grants switch with zero latency.
  always_comb begin
    flt_owns = state == ARM || state == FILTER;
    flt_enable = flt_owns;
    flt_waiting_for_new_frame = !flt_owns;
    busy = state != IDLE;
    mem_addr = flt_owns ? (flt_wr_enable ? flt_write_addr : flt_read_addr) : state == CAPTURE ? cam_addr : '0;
    mem_wr_en = flt_owns ? flt_wr_enable : state == CAPTURE && cam_wr_en && int'(cam_addr) < FRAME_PIXELS;
    mem_wdata = flt_owns ? flt_data_out : state == CAPTURE ? cam_data : '0;
  end

  always_ff @(posedge clk)
    if (!reset) begin
      done_cent <= '0;
      done_stop <= 1'b0;
      centroid <= '0;
      stop <= 1'b0;
      result_valid <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
      dropped_count <= '0;
    end else begin
      result_valid <= state == LATCH;
      if (state == FILTER && flt_frame_done) begin
        done_cent <= flt_h_centroid;
        done_stop <= flt_stop_detect;
      end
      if (state == LATCH) begin
        centroid <= done_cent;
        stop <= done_stop;
        frame_count <= frame_count + 1'b1;
      end
      if (state == FILTER && !flt_frame_done && tc) timeout_err <= 1'b1;
      if (state != IDLE && cam_frame_start && dropped_count != 8'hff) dropped_count <= dropped_count + 1'b1;
    end
endmodule

// File: tb/tb_filter_frame_sequencer.sv
// tb_filter_frame_sequencer: scoreboard bench for frame sequencing, buffer muxing and the watchdog
module tb_filter_frame_sequencer;
  localparam int TO = 1000;
  logic clk = 0, reset = 0, run_en = 0, cam_frame_start = 0, cam_frame_end = 0, cam_wr_en = 0;
  logic [16:0] cam_addr = 0, flt_read_addr = 0, flt_write_addr = 0, mem_addr;
  logic [11:0] cam_data = 0, flt_data_out = 0, mem_wdata;
  logic flt_waiting_for_new_frame, flt_enable, flt_frame_done = 0, flt_wr_enable = 0, flt_stop_detect = 0;
  logic [9:0] flt_h_centroid = 0, centroid;
  logic mem_wr_en, stop, result_valid, busy, timeout_err;
  logic [15:0] frame_count;
  logic [7:0] dropped_count;
  logic [26:0] sb[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  filter_frame_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .cam_frame_start(cam_frame_start),
    .cam_frame_end(cam_frame_end), .cam_wr_en(cam_wr_en), .cam_addr(cam_addr), .cam_data(cam_data),
    .flt_waiting_for_new_frame(flt_waiting_for_new_frame), .flt_enable(flt_enable),
    .flt_frame_done(flt_frame_done), .flt_wr_enable(flt_wr_enable), .flt_read_addr(flt_read_addr),
    .flt_write_addr(flt_write_addr), .flt_data_out(flt_data_out), .flt_h_centroid(flt_h_centroid),
    .flt_stop_detect(flt_stop_detect), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .centroid(centroid), .stop(stop), .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err),
    .frame_count(frame_count), .dropped_count(dropped_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    cam_frame_start = 1;
    tick();
    cam_frame_start = 0;
  endtask

  task automatic end_capture();
    cam_frame_end = 1;
    tick();
    cam_frame_end = 0;
    @(negedge clk);
    check("arm_enable", flt_enable, 1);
    check("arm_waiting", flt_waiting_for_new_frame, 0);
    tick();
  endtask

  task automatic finish_frame(input logic [9:0] c, input logic s, input logic [15:0] fc);
    flt_frame_done = 1;
    flt_h_centroid = c;
    flt_stop_detect = s;
    sb.push_back({fc, s, c});
    tick();
    flt_frame_done = 0;
    flt_h_centroid = 0;
    flt_stop_detect = 0;
    tick();
  endtask

  always @(negedge clk)
    if (reset && result_valid) begin
      if (sb.size() == 0) check("rv_extra", 1, 0);
      else begin
        logic [26:0] e;
        e = sb.pop_front();
        check("centroid", centroid, e[9:0]);
        check("stop", stop, e[10]);
        check("frame_count", frame_count, e[26:11]);
        check("rv_waiting", flt_waiting_for_new_frame, 1);
      end
    end

  initial begin
    logic [16:0] addrs[6] = '{0, 1, 4242, 76799, 76800, 131071};
    logic        wes[6]   = '{1, 0, 1, 1, 1, 1};
    run_en = 1;
    for (int i = 0; i < 5; i++) begin
      cam_frame_start = i[0];
      tick();
    end
    cam_frame_start = 0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped_count, 0);
    check("rst_waiting", flt_waiting_for_new_frame, 1);
    check("rst_enable", flt_enable, 0);
    check("rst_misc", {timeout_err, result_valid, stop, centroid, frame_count}, 0);
    check("rst_mem", {mem_wr_en, mem_addr}, 0);
    tick();
    reset = 1;
    start_frame();
    @(negedge clk);
    check("cap_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      cam_addr = addrs[i];
      cam_wr_en = wes[i];
      cam_data = 12'(i * 291 + 7);
      @(negedge clk);
      check("cap_wr_en", mem_wr_en, wes[i] && addrs[i] < 17'd76800);
      check("cap_addr", mem_addr, addrs[i]);
      check("cap_data", mem_wdata, 12'(i * 291 + 7));
      tick();
    end
    cam_wr_en = 0;
    end_capture();
    flt_read_addr = 100;
    cam_wr_en = 1;
    cam_addr = 5;
    @(negedge clk);
    check("flt_rd_addr", mem_addr, 100);
    check("flt_rd_we", mem_wr_en, 0);
    tick();
    flt_wr_enable = 1;
    flt_write_addr = 200;
    flt_data_out = 12'habc;
    cam_frame_start = 1;
    @(negedge clk);
    check("flt_wr_addr", mem_addr, 200);
    check("flt_wr_we", mem_wr_en, 1);
    check("flt_wr_data", mem_wdata, 12'habc);
    tick();
    cam_frame_start = 0;
    flt_wr_enable = 0;
    cam_wr_en = 0;
    @(negedge clk);
    check("dropped_1", dropped_count, 1);
    run_en = 0;
    tick();
    @(negedge clk);
    check("flt_no_abort", busy, 1);
    run_en = 1;
    finish_frame(10'd160, 1'b1, 16'd1);
    run_en = 0;
    cam_frame_start = 1;
    tick();
    cam_frame_start = 0;
    @(negedge clk);
    check("idle_ignore_busy", busy, 0);
    check("idle_ignore_drop", dropped_count, 1);
    run_en = 1;
    start_frame();
    end_capture();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      cam_frame_start = i[0];
    end
    cam_frame_start = 0;
    @(negedge clk);
    check("wd_last_busy", busy, 1);
    check("wd_last_err", timeout_err, 0);
    tick();
    @(negedge clk);
    check("wd_busy", busy, 0);
    check("wd_err", timeout_err, 1);
    check("wd_frames", frame_count, 1);
    check("drop_sat", dropped_count, 255);
    start_frame();
    end_capture();
    repeat (TO - 1) tick();
    finish_frame(10'd511, 1'b0, 16'd2);
    tick();
    start_frame();
    run_en = 0;
    tick();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_enable", flt_enable, 0);
    tick();
    @(negedge clk);
    check("abort_no_arm", flt_enable, 0);
    check("abort_frames", frame_count, 2);
    check("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
